// File: rtl/io_bridge_if.sv
// ============================================================================
// Module      : io_bridge_if
// Description : Core-side word port and byte-stream port of io_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface io_bridge_if;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        in_issued;
  logic        in_stall;
  logic [31:0] in_data;
  logic [31:0] status;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  // Environment side: the core plus the byte transmitter/receiver.
  modport master (
    output out_issued, out_data, in_issued, tx_ready, rx_data, rx_valid,
    input  out_stall, in_stall, in_data, status, tx_data, tx_valid, rx_ready
  );

  // Bridge side.
  modport slave (
    input  out_issued, out_data, in_issued, tx_ready, rx_data, rx_valid,
    output out_stall, in_stall, in_data, status, tx_data, tx_valid, rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/io_bridge.sv
// ============================================================================
// Module      : io_bridge
// Description : 32-bit core word port to 8-bit byte streams via TX/RX FIFOs.
//               Optional status word enabled by macro IO_BRIDGE_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module io_bridge #(
  parameter int DEPTH_LOG2 = 3
) (
  input  wire logic   clk,
  input  wire logic   rst,
  io_bridge_if.slave  bus
);

  localparam int                c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // --------------------------------------------------------------------------
  // TX word FIFO
  // --------------------------------------------------------------------------
  logic [31:0]           r_tx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_tx_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_tx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_tx_count;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_tx_push;
  logic                  w_tx_pop;

  // Full/empty come from registered occupancy only, so a pop in the same
  // cycle never lets a push through while full.
  assign w_tx_full     = (r_tx_count == c_FULL);
  assign w_tx_empty    = (r_tx_count == '0);
  assign w_tx_push     = bus.out_issued & ~w_tx_full;
  assign bus.out_stall = bus.out_issued & w_tx_full;

  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr_ptr] <= bus.out_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr_ptr <= r_tx_wr_ptr + 1'b1;
      end
      if (w_tx_pop) begin
        r_tx_rd_ptr <= r_tx_rd_ptr + 1'b1;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Serializer
  // --------------------------------------------------------------------------
  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic        w_load;
  logic        w_tx_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_tx_pop    = 1'b0;
    w_tx_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_tx_empty) begin
          w_tx_pop    = 1'b1;
          w_load      = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_tx_valid = 1'b1;
        if (bus.tx_ready) begin
          if (r_idx == 2'd3) begin
            // Chain straight into the next word so bytes stay back-to-back.
            w_idx_nxt = 2'd0;
            if (!w_tx_empty) begin
              w_tx_pop = 1'b1;
              w_load   = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_load) begin
        r_shift <= r_tx_mem[r_tx_rd_ptr];
      end
    end
  end

  assign bus.tx_valid = w_tx_valid;
  assign bus.tx_data  = w_tx_valid ? r_shift[{r_idx, 3'b000} +: 8] : 8'h00;

  // --------------------------------------------------------------------------
  // RX assembler
  // --------------------------------------------------------------------------
  logic [31:0]           r_rx_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_rx_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rx_rd_ptr;
  logic [DEPTH_LOG2:0]   r_rx_count;
  logic [1:0]            r_rx_bcnt;
  logic [23:0]           r_rx_asm;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic                  w_rx_ready;
  logic                  w_rx_take;
  logic                  w_rx_push;
  logic                  w_rx_pop;

  assign w_rx_full  = (r_rx_count == c_FULL);
  assign w_rx_empty = (r_rx_count == '0);
  // Only the word-completing byte needs FIFO room; earlier bytes always fit.
  assign w_rx_ready = ~((r_rx_bcnt == 2'd3) & w_rx_full);
  assign w_rx_take  = bus.rx_valid & w_rx_ready;
  assign w_rx_push  = w_rx_take & (r_rx_bcnt == 2'd3);
  assign w_rx_pop   = bus.in_issued & ~w_rx_empty;

  assign bus.rx_ready = w_rx_ready;
  assign bus.in_stall = bus.in_issued & w_rx_empty;
  assign bus.in_data  = w_rx_empty ? 32'h0 : r_rx_mem[r_rx_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr_ptr] <= {bus.rx_data, r_rx_asm};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_bcnt <= 2'd0;
      r_rx_asm  <= '0;
    end else if (w_rx_take) begin
      r_rx_bcnt <= r_rx_bcnt + 1'b1;
      case (r_rx_bcnt)
        2'd0:    r_rx_asm[7:0]   <= bus.rx_data;
        2'd1:    r_rx_asm[15:8]  <= bus.rx_data;
        2'd2:    r_rx_asm[23:16] <= bus.rx_data;
        default: r_rx_asm        <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wr_ptr <= r_rx_wr_ptr + 1'b1;
      end
      if (w_rx_pop) begin
        r_rx_rd_ptr <= r_rx_rd_ptr + 1'b1;
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status word
  // --------------------------------------------------------------------------
`ifdef IO_BRIDGE_STATUS_EN
  logic r_rx_blocked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_blocked <= 1'b0;
    end else if (bus.rx_valid && !w_rx_ready) begin
      r_rx_blocked <= 1'b1;
    end
  end

  assign bus.status = {14'd0, r_rx_blocked, (r_state == ST_SEND),
                       8'(r_rx_count), 8'(r_tx_count)};
`else
  assign bus.status = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_bridge.sv
// ============================================================================
// Module      : tb_io_bridge
// Description : Scoreboard bench for io_bridge: directed TX/RX/reset vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_io_bridge;

  logic clk = 1'b0;
  logic rst;

  io_bridge_if bus ();

  io_bridge #(.DEPTH_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_q [$];
  logic [31:0] rx_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_none(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) tx_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic send_rx_byte(input logic [7:0] b);
    cyc();
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  // Monitor: every handshake seen on the DUT outputs is checked against the
  // next expected item.
  always @(negedge clk) begin : monitor
    logic [7:0]  e8;
    logic [31:0] e32;
    if (rst === 1'b1) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (tx_q.size() == 0) chk_none("tx_unexpected_byte", {24'd0, bus.tx_data});
        else begin
          e8 = tx_q.pop_front();
          chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, e8});
        end
      end
      if (bus.in_issued && !bus.in_stall) begin
        if (rx_q.size() == 0) chk_none("rx_unexpected_word", bus.in_data);
        else begin
          e32 = rx_q.pop_front();
          chk("rx_word", bus.in_data, e32);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] w9;
    logic [31:0] rw;
    int          k;
    int          seen;

    rst            = 1'b1;
    bus.out_issued = 1'b0;
    bus.out_data   = '0;
    bus.in_issued  = 1'b1;
    bus.tx_ready   = 1'b0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    #2 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid",  {31'd0, bus.tx_valid},  32'd0);
    chk("rst_tx_data",   {24'd0, bus.tx_data},   32'd0);
    chk("rst_rx_ready",  {31'd0, bus.rx_ready},  32'd1);
    chk("rst_status",    bus.status,             32'd0);
    chk("rst_out_stall", {31'd0, bus.out_stall}, 32'd0);
    chk("rst_in_stall",  {31'd0, bus.in_stall},  32'd1);
    chk("rst_in_data",   bus.in_data,            32'd0);
    cyc();
    rst           = 1'b1;
    bus.in_issued = 1'b0;
    cyc();

    // Single word, latency and byte order
    cyc();
    bus.out_issued = 1'b1;
    bus.out_data   = 32'hDDCCBBAA;
    bus.tx_ready   = 1'b1;
    push_tx_word(32'hDDCCBBAA);
    @(negedge clk);
    chk("t29_c0_out_stall", {31'd0, bus.out_stall}, 32'd0);
    chk("t29_c0_valid",     {31'd0, bus.tx_valid},  32'd0);
    cyc();
    bus.out_issued = 1'b0;
    @(negedge clk);
    chk("t29_c1_valid", {31'd0, bus.tx_valid}, 32'd0);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      @(negedge clk);
      chk("t29_valid_c2to5", {31'd0, bus.tx_valid}, 32'd1);
    end
    cyc();
    @(negedge clk);
    chk("t29_c6_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("t29_tx_q_empty", tx_q.size(), 32'd0);

    // Fill TX FIFO with the transmitter stalled
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      w = 32'hA0B0C0D0 ^ (i * 32'h01010101);
      bus.out_issued = 1'b1;
      bus.out_data   = w;
      push_tx_word(w);
      @(negedge clk);
      chk("t30_no_stall", {31'd0, bus.out_stall}, 32'd0);
    end
    cyc();
    w9 = 32'h0F1E2D3C;
    bus.out_data = w9;
    @(negedge clk);
    chk("t30_stall_10th", {31'd0, bus.out_stall}, 32'd1);
    chk("t30_hold_valid", {31'd0, bus.tx_valid},  32'd1);
    chk("t30_hold_byte",  {24'd0, bus.tx_data},   32'h000000D0);
    cyc();
    bus.tx_ready = 1'b1;
    seen = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.out_stall) begin
        seen = 1;
        break;
      end
      cyc();
    end
    chk("t30_stall_released", seen, 32'd1);
    if (seen == 1) push_tx_word(w9);
    cyc();
    bus.out_issued = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_q.size() == 0) break;
      chk("t30_no_gap", {31'd0, bus.tx_valid}, 32'd1);
      cyc();
    end
    chk("t30_drained", tx_q.size(), 32'd0);
    cyc();
    cyc();
    @(negedge clk);
    chk("t30_idle_after", {31'd0, bus.tx_valid}, 32'd0);

    // RX single word
    rw = 32'h44332211;
    for (int b = 0; b < 4; b++) begin
      send_rx_byte(rw[b*8 +: 8]);
      @(negedge clk);
      chk("t31_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    end
    rx_q.push_back(rw);
    cyc();
    bus.rx_valid  = 1'b0;
    bus.in_issued = 1'b1;
    @(negedge clk);
    chk("t31_in_stall_low", {31'd0, bus.in_stall}, 32'd0);
    cyc();
    @(negedge clk);
    chk("t31_in_stall_empty", {31'd0, bus.in_stall}, 32'd1);
    cyc();
    bus.in_issued = 1'b0;

    // RX FIFO full, partial word blocked
    for (int i = 0; i < 8; i++) begin
      w = {8'hE0 + 8'(i), 8'hA0 + 8'(i), 8'h50 + 8'(i), 8'h10 + 8'(i)};
      for (int b = 0; b < 4; b++) send_rx_byte(w[b*8 +: 8]);
      rx_q.push_back(w);
    end
    rw = 32'h99887766;
    for (int b = 0; b < 3; b++) send_rx_byte(rw[b*8 +: 8]);
    rx_q.push_back(rw);
    send_rx_byte(rw[31:24]);
    @(negedge clk);
    chk("t32_rx_ready_low", {31'd0, bus.rx_ready}, 32'd0);
    cyc();
    bus.in_issued = 1'b1;
    @(negedge clk);
    chk("t32_rx_ready_still_low", {31'd0, bus.rx_ready}, 32'd0);
    cyc();
    bus.in_issued = 1'b0;
    @(negedge clk);
    chk("t32_rx_ready_back", {31'd0, bus.rx_ready}, 32'd1);
    cyc();
    bus.rx_valid = 1'b0;
    @(negedge clk);
`ifdef IO_BRIDGE_STATUS_EN
    chk("t32_status", bus.status, 32'h00020800);
`else
    chk("t32_status", bus.status, 32'h00000000);
`endif
    cyc();
    bus.in_issued = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rx_q.size() == 0) break;
      cyc();
    end
    cyc();
    bus.in_issued = 1'b0;
    chk("t32_rx_drained", rx_q.size(), 32'd0);

    // Reset in the middle of byte 2
    cyc();
    bus.out_issued = 1'b1;
    bus.out_data   = 32'h87654321;
    bus.tx_ready   = 1'b1;
    tx_q.push_back(8'h21);
    tx_q.push_back(8'h43);
    cyc();
    bus.out_issued = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("t33_valid_in_rst",  {31'd0, bus.tx_valid}, 32'd0);
    chk("t33_data_in_rst",   {24'd0, bus.tx_data},  32'd0);
    chk("t33_status_in_rst", bus.status,            32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.tx_valid) seen++;
      cyc();
    end
    chk("t33_no_bytes_after", seen, 32'd0);
    chk("t33_tx_q_empty", tx_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
